// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver
// Description : Multiplexed 7-segment scan driver. Once per refresh frame the
//               per-digit hex nibbles and decimal-point requests are copied
//               into shadow registers. Digits are then scanned one slot at a
//               time onto a shared segment bus with one-hot digit enables.
//               Each slot opens with a dark blanking window against ghosting.
//               Optional leading-zero suppression is applied on the fly.
// Ports       : clk          - system clock
//               reset_n      - asynchronous active-low reset
//               enable       - scan enable; low holds the block idle and dark
//               digits_in    - nibble i at [4i+3:4i], digit 0 least significant
//               dp_in        - decimal point request per digit
//               lz_suppress  - leading-zero suppression enable (live)
//               seg          - segments {g,f,e,d,c,b,a}
//               dp           - decimal point segment
//               an           - one-hot digit enable
//               frame_start  - one-cycle pulse after each frame snapshot
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_suppress,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int SW = $clog2(NUM_DIGITS);

    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYCLES);
    localparam logic [SW-1:0] SLOT_MAX  = SW'(NUM_DIGITS - 1);

    // Inactive pin levels; XOR-ing an active-high pattern with these also
    // converts it to the configured polarity.
    localparam logic [6:0]            SEG_OFF = {7{ACTIVE_LOW}};
    localparam logic                  DP_OFF  = ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{ACTIVE_LOW}};

    // Hex to active-high gfedcba pattern.
    function automatic logic [6:0] f_decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0: pat = 7'h3F;
            4'h1: pat = 7'h06;
            4'h2: pat = 7'h5B;
            4'h3: pat = 7'h4F;
            4'h4: pat = 7'h66;
            4'h5: pat = 7'h6D;
            4'h6: pat = 7'h7D;
            4'h7: pat = 7'h07;
            4'h8: pat = 7'h7F;
            4'h9: pat = 7'h6F;
            4'hA: pat = 7'h77;
            4'hB: pat = 7'h7C;
            4'hC: pat = 7'h39;
            4'hD: pat = 7'h5E;
            4'hE: pat = 7'h79;
            default: pat = 7'h71;
        endcase
        return pat;
    endfunction

    logic [PW-1:0]           presc_q, presc_d;
    logic [SW-1:0]           slot_q, slot_d;
    logic [4*NUM_DIGITS-1:0] shadow_q;
    logic [NUM_DIGITS-1:0]   shadow_dp_q;
    logic                    frame_start_q;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;

    logic                    w_snap;
    logic                    w_drive;
    logic [NUM_DIGITS-1:0]   w_zero_from;
    logic [NUM_DIGITS-1:0]   w_onehot;
    logic [3:0]              w_nib;
    logic                    w_dp_req;
    logic                    w_sup;

    // Snapshot at the first cycle of every frame; disabling forces the
    // counters back to (0,0) so re-enabling snapshots immediately.
    assign w_snap   = enable && (slot_q == '0) && (presc_q == '0);
    assign w_drive  = enable && (presc_q >= BLANK_END);
    assign w_onehot = NUM_DIGITS'(1) << slot_q;

    always_comb begin
        presc_d = presc_q;
        slot_d  = slot_q;
        if (!enable) begin
            presc_d = '0;
            slot_d  = '0;
        end else if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            slot_d  = (slot_q == SLOT_MAX) ? '0 : slot_q + 1'b1;
        end else begin
            presc_d = presc_q + 1'b1;
        end
    end

    // w_zero_from[i]: shadow digit i and every digit above it are zero.
    always_comb begin
        logic v_acc;
        v_acc       = 1'b1;
        w_zero_from = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            v_acc          = v_acc && (shadow_q[4*i +: 4] == 4'h0);
            w_zero_from[i] = v_acc;
        end
    end

    // Select the shadow digit for the current slot.
    always_comb begin
        w_nib    = '0;
        w_dp_req = 1'b0;
        w_sup    = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (slot_q == SW'(i)) begin
                w_nib    = shadow_q[4*i +: 4];
                w_dp_req = shadow_dp_q[i];
                w_sup    = lz_suppress && (i != 0) && w_zero_from[i];
            end
        end
    end

    // A suppressed digit keeps its segments dark but still lights its anode
    // when a decimal point is requested so the dp remains visible.
    always_comb begin
        seg_d = SEG_OFF;
        dp_d  = DP_OFF;
        an_d  = AN_OFF;
        if (w_drive) begin
            dp_d = w_dp_req ^ DP_OFF;
            if (!w_sup) begin
                seg_d = f_decode(w_nib) ^ SEG_OFF;
                an_d  = w_onehot ^ AN_OFF;
            end else if (w_dp_req) begin
                an_d  = w_onehot ^ AN_OFF;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q       <= '0;
            slot_q        <= '0;
            shadow_q      <= '0;
            shadow_dp_q   <= '0;
            frame_start_q <= 1'b0;
            seg_q         <= SEG_OFF;
            dp_q          <= DP_OFF;
            an_q          <= AN_OFF;
        end else begin
            presc_q       <= presc_d;
            slot_q        <= slot_d;
            frame_start_q <= w_snap;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            an_q          <= an_d;
            if (w_snap) begin
                shadow_q    <= digits_in;
                shadow_dp_q <= dp_in;
            end
        end
    end

    assign seg         = seg_q;
    assign dp          = dp_q;
    assign an          = an_q;
    assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_driver
// Description : Self-checking bench for seg7_scan_driver. Two instances share
//               all inputs, one active-low and one active-high. A cycle model
//               pushes the expected active-high pin pattern into a scoreboard
//               queue as each cycle is driven; it is popped and compared to
//               both instances after the edge. Directed spot checks against
//               literal pin values cover the key scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

    localparam int ND    = 4;
    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam logic [12:0] AL_MASK = 13'h1FFE;  // invert seg, dp, an; keep frame_start

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic        lz_suppress;

    logic [6:0]  seg_al, seg_ah;
    logic        dp_al, dp_ah;
    logic [3:0]  an_al, an_ah;
    logic        fs_al, fs_ah;
    logic [12:0] obs_al, obs_ah;

    assign obs_al = {seg_al, dp_al, an_al, fs_al};
    assign obs_ah = {seg_ah, dp_ah, an_ah, fs_ah};

    always #5 clk = ~clk;

    seg7_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(DIV), .BLANK_CYCLES(BLANK), .ACTIVE_LOW(1'b1)) dut_al (
        .clk(clk), .reset_n(reset_n), .enable(enable), .digits_in(digits_in),
        .dp_in(dp_in), .lz_suppress(lz_suppress),
        .seg(seg_al), .dp(dp_al), .an(an_al), .frame_start(fs_al)
    );

    seg7_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(DIV), .BLANK_CYCLES(BLANK), .ACTIVE_LOW(1'b0)) dut_ah (
        .clk(clk), .reset_n(reset_n), .enable(enable), .digits_in(digits_in),
        .dp_in(dp_in), .lz_suppress(lz_suppress),
        .seg(seg_ah), .dp(dp_ah), .an(an_ah), .frame_start(fs_ah)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [12:0] sb_q[$];

    int          m_presc, m_slot;
    logic [15:0] m_sh;
    logic [3:0]  m_shdp;
    logic [6:0]  dec_tab [16];

    initial begin
        dec_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    end

    function automatic void model_reset();
        m_presc = 0;
        m_slot  = 0;
        m_sh    = '0;
        m_shdp  = '0;
    endfunction

    // Active-high {seg,dp,an,frame_start} expected after the coming edge.
    function automatic logic [12:0] model_out();
        logic [6:0] s;
        logic       d, f, sup;
        logic [3:0] a, nib;
        s = '0; d = 1'b0; a = '0; f = 1'b0;
        if (reset_n && enable) begin
            f = (m_slot == 0) && (m_presc == 0);
            if (m_presc >= BLANK) begin
                nib = m_sh[4*m_slot +: 4];
                d   = m_shdp[m_slot];
                sup = lz_suppress && (m_slot != 0) && ((m_sh >> (4*m_slot)) == 16'h0);
                if (!sup) s = dec_tab[nib];
                if (!sup || d) a = 4'b0001 << m_slot;
            end
        end
        return {s, d, a, f};
    endfunction

    function automatic void model_update();
        if (!reset_n) begin
            model_reset();
        end else if (!enable) begin
            m_presc = 0;
            m_slot  = 0;
        end else begin
            if (m_presc == 0 && m_slot == 0) begin
                m_sh   = digits_in;
                m_shdp = dp_in;
            end
            m_presc++;
            if (m_presc == DIV) begin
                m_presc = 0;
                m_slot  = (m_slot + 1) % ND;
            end
        end
    endfunction

    task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic spot(input string tag, input logic [12:0] obs,
                        input logic [6:0] s, input logic d, input logic [3:0] a, input logic f);
        check(tag, obs, {s, d, a, f});
    endtask

    task automatic step(input string tag);
        logic [12:0] exp;
        sb_q.push_back(model_out());
        @(posedge clk);
        model_update();
        #1;
        exp = sb_q.pop_front();
        check({tag, "/al"}, obs_al, exp ^ AL_MASK);
        check({tag, "/ah"}, obs_ah, exp);
    endtask

    task automatic steps(input int n, input string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n     = 1'b0;
        enable      = 1'b1;
        digits_in   = 16'hFFFF;
        dp_in       = 4'hF;
        lz_suppress = 1'b1;
        model_reset();

        // Reset holds everything dark whatever the inputs.
        steps(2, "reset");
        spot("reset_al", obs_al, 7'h7F, 1'b1, 4'hF, 1'b0);
        spot("reset_ah", obs_ah, 7'h00, 1'b0, 4'h0, 1'b0);

        // Basic scan of 1234.
        reset_n     = 1'b1;
        digits_in   = 16'h1234;
        dp_in       = 4'h0;
        lz_suppress = 1'b0;
        step("snap0");
        spot("first_frame_start", obs_al, 7'h7F, 1'b1, 4'hF, 1'b1);
        steps(2, "scan");
        spot("slot0_4", obs_al, 7'h19, 1'b1, 4'hE, 1'b0);
        steps(9, "scan");
        spot("slot1_3", obs_al, 7'h30, 1'b1, 4'hD, 1'b0);

        // Snapshot isolation: change inputs mid-frame.
        digits_in = 16'hABCD;
        steps(8, "iso");
        spot("slot2_2", obs_al, 7'h24, 1'b1, 4'hB, 1'b0);
        steps(8, "iso");
        spot("slot3_1", obs_al, 7'h79, 1'b1, 4'h7, 1'b0);
        steps(5, "iso");
        spot("frame_start_32", obs_al, 7'h7F, 1'b1, 4'hF, 1'b1);
        steps(2, "abcd");
        spot("slot0_D", obs_al, 7'h21, 1'b1, 4'hE, 1'b0);
        steps(8, "abcd");
        spot("slot1_C", obs_al, 7'h46, 1'b1, 4'hD, 1'b0);
        steps(8, "abcd");
        spot("slot2_b", obs_al, 7'h03, 1'b1, 4'hB, 1'b0);
        steps(8, "abcd");
        spot("slot3_A", obs_al, 7'h08, 1'b1, 4'h7, 1'b0);

        // Leading-zero suppression.
        digits_in   = 16'h0050;
        lz_suppress = 1'b1;
        steps(8, "lz");
        spot("lz_slot0_0", obs_al, 7'h40, 1'b1, 4'hE, 1'b0);
        steps(8, "lz");
        spot("lz_slot1_5", obs_al, 7'h12, 1'b1, 4'hD, 1'b0);
        steps(8, "lz");
        spot("lz_slot2_dark", obs_al, 7'h7F, 1'b1, 4'hF, 1'b0);
        steps(8, "lz");
        spot("lz_slot3_dark", obs_al, 7'h7F, 1'b1, 4'hF, 1'b0);
        dp_in = 4'b1000;
        steps(32, "lzdp");
        spot("lz_slot3_dp", obs_al, 7'h7F, 1'b0, 4'h7, 1'b0);

        // Enable drop during slot 2 DRIVE.
        lz_suppress = 1'b0;
        dp_in       = 4'h0;
        digits_in   = 16'h9876;
        steps(25, "pre_en");
        spot("slot2_8", obs_al, 7'h00, 1'b1, 4'hB, 1'b0);
        enable = 1'b0;
        step("en_drop");
        spot("en_drop_dark", obs_al, 7'h7F, 1'b1, 4'hF, 1'b0);
        digits_in = 16'h4321;
        steps(3, "disabled");
        enable = 1'b1;
        step("en_back");
        spot("en_back_fs", obs_al, 7'h7F, 1'b1, 4'hF, 1'b1);
        steps(2, "en_back");
        spot("en_back_slot0_1", obs_al, 7'h79, 1'b1, 4'hE, 1'b0);

        // Active-high polarity and reset mid-DRIVE.
        digits_in = 16'h0008;
        steps(30, "ah");
        spot("ah_frame_start", obs_ah, 7'h00, 1'b0, 4'h0, 1'b1);
        steps(2, "ah");
        spot("ah_slot0_8", obs_ah, 7'h7F, 1'b0, 4'h1, 1'b0);
        reset_n = 1'b0;
        #1;
        model_reset();
        spot("async_reset_ah", obs_ah, 7'h00, 1'b0, 4'h0, 1'b0);
        spot("async_reset_al", obs_al, 7'h7F, 1'b1, 4'hF, 1'b0);
        steps(2, "in_reset");
        reset_n = 1'b1;
        step("restart");
        spot("restart_fs", obs_ah, 7'h00, 1'b0, 4'h0, 1'b1);
        steps(2, "restart");
        spot("restart_slot0", obs_ah, 7'h7F, 1'b0, 4'h1, 1'b0);
        steps(8, "restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
